// File: rtl/gj_axis_uart_rx_fifo.sv
// gj_axis_uart_rx_fifo: oversampling UART receiver feeding an AXI-Stream FWFT FIFO.
// Frame format is selectable at runtime: 5..9 data bits, none/odd/even parity,
// and 1 or 2 stop bits. Each stored character carries {break, frame_err, parity_err}.
module gj_axis_uart_rx_fifo #(
    parameter int OVS   = 16,
    parameter int DW    = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic [3:0]               cfg_dbits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    input  logic                     rx,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [DW-1:0]            m_tdata,
    output logic [2:0]               m_tuser,
    output logic                     overflow,
    output logic                     start_err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(OVS);
    localparam int WW = 12;  // {break, frame_err, parity_err, data[8:0]}

    localparam logic [PW-1:0] PH_S0   = PW'(OVS/2 - 1);
    localparam logic [PW-1:0] PH_S1   = PW'(OVS/2);
    localparam logic [PW-1:0] PH_DEC  = PW'(OVS/2 + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVS - 1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BRKWAIT
    } state_t;

    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    // Input synchroniser and edge-detect history
    logic            r_rx_meta;
    logic            r_rxs;
    logic            r_rx_last;

    // Receive FSM state
    state_t          r_state;
    logic [PW-1:0]   r_phase;
    logic            r_s0;
    logic            r_s1;
    logic [3:0]      r_bitcnt;
    logic [8:0]      r_data;
    logic            r_par;
    logic            r_any_one;
    logic            r_ferr;
    logic            r_brk;
    logic            r_perr;
    logic            r_start_err;

    // Configuration shadow, frozen for the duration of a frame
    logic [3:0]      r_dbits;
    logic [1:0]      r_pmode;
    logic            r_stop2;

    // FIFO
    logic [WW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_level;
    logic            r_overflow;

    logic            w_maj;
    logic            w_dec;
    logic            w_par_en;
    logic            w_par_exp;
    logic [3:0]      w_dbits_norm;
    logic            w_push;
    logic            w_push_brk;
    logic            w_push_ferr;
    logic [WW-1:0]   w_push_word;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic [WW-1:0]   w_head;
    logic [DW-1:0]   w_tdata;

    assign w_maj        = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);
    assign w_dec        = clk_en && (r_phase == PH_DEC);
    assign w_par_en     = (r_pmode == PAR_ODD) || (r_pmode == PAR_EVEN);
    assign w_par_exp    = (r_pmode == PAR_ODD) ? ~r_par : r_par;
    assign w_dbits_norm = (cfg_dbits >= 4'd5 && cfg_dbits <= 4'd9) ? cfg_dbits : 4'd8;

    // Two-flop synchroniser on rx; last-sampled value tracked on oversample ticks
    // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rx_last <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
            if (clk_en) r_rx_last <= r_rxs;
        end
    end

    // Completion of a character at the final stop-bit decision tick
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_push      = 1'b0;
        w_push_brk  = 1'b0;
        w_push_ferr = 1'b0;
        if (w_dec) begin
            case (r_state)
                S_STOP1: begin
                    if (!r_stop2) begin
                        w_push      = 1'b1;
                        w_push_ferr = r_ferr | ~w_maj;
                        w_push_brk  = ~r_any_one & ~w_maj;
                    end
                end
                S_STOP2: begin
                    w_push      = 1'b1;
                    w_push_ferr = r_ferr | ~w_maj;
                    w_push_brk  = r_brk;
                end
                default: ;
            endcase
        end
    end

    assign w_push_word = {w_push_brk, w_push_ferr, r_perr, r_data};

    // Receive FSM: start detection, bit timing, majority sampling and frame checks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_bitcnt    <= '0;
            r_data      <= '0;
            r_par       <= 1'b0;
            r_any_one   <= 1'b0;
            r_ferr      <= 1'b0;
            r_brk       <= 1'b0;
            r_perr      <= 1'b0;
            r_start_err <= 1'b0;
            r_dbits     <= 4'd8;
            r_pmode     <= 2'd0;
            r_stop2     <= 1'b0;
        end else begin
            r_start_err <= 1'b0;
            if (clk_en) begin
                if (r_state != S_IDLE && r_state != S_BRKWAIT) begin
                    r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
                    if (r_phase == PH_S0) r_s0 <= r_rxs;
                    if (r_phase == PH_S1) r_s1 <= r_rxs;
                end
                case (r_state)
                    S_IDLE: begin
                        if (r_rx_last && !r_rxs) begin
                            r_state   <= S_START;
                            r_phase   <= '0;
                            r_dbits   <= w_dbits_norm;
                            r_pmode   <= cfg_parity;
                            r_stop2   <= cfg_stop2;
                            r_bitcnt  <= '0;
                            r_data    <= '0;
                            r_par     <= 1'b0;
                            r_any_one <= 1'b0;
                            r_ferr    <= 1'b0;
                            r_brk     <= 1'b0;
                            r_perr    <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (w_dec) begin
                            if (w_maj) begin
                                r_start_err <= 1'b1;
                                r_state     <= S_IDLE;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_dec) begin
                            r_data[r_bitcnt] <= w_maj;
                            r_par            <= r_par ^ w_maj;
                            r_any_one        <= r_any_one | w_maj;
                            if (r_bitcnt == r_dbits - 4'd1) begin
                                r_state <= w_par_en ? S_PARITY : S_STOP1;
                            end else begin
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (w_dec) begin
                            r_perr    <= (w_maj != w_par_exp);
                            r_any_one <= r_any_one | w_maj;
                            r_state   <= S_STOP1;
                        end
                    end
                    S_STOP1: begin
                        if (w_dec) begin
                            if (r_stop2) begin
                                r_ferr  <= r_ferr | ~w_maj;
                                r_brk   <= ~r_any_one & ~w_maj;
                                r_state <= S_STOP2;
                            end else begin
                                r_state <= w_push_brk ? S_BRKWAIT : S_IDLE;
                            end
                        end
                    end
                    S_STOP2: begin
                        if (w_dec) r_state <= w_push_brk ? S_BRKWAIT : S_IDLE;
                    end
                    S_BRKWAIT: begin
                        if (r_rxs) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_full = (r_level == LVL_FULL);
    assign w_pop  = m_tvalid & m_tready;
    assign w_wr   = w_push & (~w_full | w_pop);

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push & w_full & ~w_pop;
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage write port
    // NOTE: storage is deliberately not reset; outputs are gated by m_tvalid instead.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_push_word;
    end

    // First-word-fall-through head, zeroed while the FIFO is empty
    always_comb begin
        w_head  = r_mem[r_rptr];
        w_tdata = '0;
        if (m_tvalid) w_tdata[8:0] = w_head[8:0];
    end

    assign m_tvalid  = (r_level != '0);
    assign m_tdata   = w_tdata;
    assign m_tuser   = m_tvalid ? w_head[11:9] : 3'b000;
    assign overflow  = r_overflow;
    assign start_err = r_start_err;
    assign level     = r_level;

endmodule

// File: tb/tb_gj_axis_uart_rx_fifo.sv
// Directed testbench for gj_axis_uart_rx_fifo: serial frames are driven bit by bit,
// accepted beats are logged by a monitor, and each result is checked against
// hand-computed values.
module tb_gj_axis_uart_rx_fifo;

    localparam int OVS   = 16;
    localparam int DW    = 9;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clk_en = 1'b0;
    logic [3:0]      cfg_dbits = 4'd8;
    logic [1:0]      cfg_parity = 2'd0;
    logic            cfg_stop2 = 1'b0;
    logic            rx = 1'b1;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [DW-1:0]   m_tdata;
    logic [2:0]      m_tuser;
    logic            overflow;
    logic            start_err;
    logic [LW-1:0]   level;

    int vectors    = 0;
    int miscompares = 0;

    logic [8:0] q_data [$];
    logic [2:0] q_user [$];
    int ovf_cnt  = 0;
    int serr_cnt = 0;

    gj_axis_uart_rx_fifo #(.OVS(OVS), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .cfg_dbits  (cfg_dbits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .rx         (rx),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tuser    (m_tuser),
        .overflow   (overflow),
        .start_err  (start_err),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Oversample tick: high on every other clk, one clk wide
    initial begin
        forever begin
            @(negedge clk);
            clk_en = ~clk_en;
        end
    end

    // Monitor: log accepted beats and count pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                q_data.push_back(m_tdata[8:0]);
                q_user.push_back(m_tuser);
            end
            if (overflow)  ovf_cnt++;
            if (start_err) serr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (clk_en !== 1'b1);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        wait_ticks(OVS);
    endtask

    task automatic set_cfg(input logic [3:0] d, input logic [1:0] p, input logic s2);
        @(negedge clk);
        cfg_dbits  = d;
        cfg_parity = p;
        cfg_stop2  = s2;
    endtask

    // Start bit, data LSB first, optional parity, stop bit(s), then two idle bits
    task automatic send_frame(input logic [8:0] d, input int nbits, input int pmode,
                              input bit pflip, input bit stop_low, input bit two_stop);
        logic p;
        p = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(d[i]);
            p = p ^ d[i];
        end
        if (pmode == 1 || pmode == 2) begin
            if (pmode == 1) p = ~p;
            send_bit(p ^ pflip);
        end
        send_bit(~stop_low);
        if (two_stop) send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic expect_beat(input string tag, input logic [8:0] d, input logic [2:0] u);
        logic [8:0] od;
        logic [2:0] ou;
        od = 'x;
        ou = 'x;
        if (q_data.size() > 0) begin
            od = q_data.pop_front();
            ou = q_user.pop_front();
        end
        check({tag, "_data"}, 32'(od), 32'(d));
        check({tag, "_user"}, 32'(ou), 32'(u));
    endtask

    initial begin
        // Reset state, checked while reset is still asserted
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_tvalid",    32'(m_tvalid),  32'd0);
        check("rst_tdata",     32'(m_tdata),   32'd0);
        check("rst_tuser",     32'(m_tuser),   32'd0);
        check("rst_level",     32'(level),     32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_start_err", 32'(start_err), 32'd0);
        rst = 1'b0;
        wait_ticks(2 * OVS);

        // 1: 8N1 0xA5 with sink ready
        m_tready = 1'b1;
        set_cfg(4'd8, 2'd0, 1'b0);
        send_frame(9'h0A5, 8, 0, 0, 0, 0);
        check("t1_count", 32'(q_data.size()), 32'd1);
        expect_beat("t1", 9'h0A5, 3'b000);
        check("t1_level", 32'(level), 32'd0);

        // 2: 7E2, correct parity then flipped parity
        set_cfg(4'd7, 2'd2, 1'b1);
        send_frame(9'h03C, 7, 2, 0, 0, 1);
        expect_beat("t2a", 9'h03C, 3'b000);
        send_frame(9'h03C, 7, 2, 1, 0, 1);
        expect_beat("t2b", 9'h03C, 3'b001);

        // 3: framing error, then a clean frame
        set_cfg(4'd8, 2'd0, 1'b0);
        send_frame(9'h055, 8, 0, 0, 1, 0);
        expect_beat("t3a", 9'h055, 3'b010);
        send_frame(9'h012, 8, 0, 0, 0, 0);
        expect_beat("t3b", 9'h012, 3'b000);

        // 4: false start of 4 ticks
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(3 * OVS);
        check("t4_start_err", 32'(serr_cnt), 32'd1);
        check("t4_no_beat", 32'(q_data.size()), 32'd0);
        send_frame(9'h05A, 8, 0, 0, 0, 0);
        expect_beat("t4_after", 9'h05A, 3'b000);

        // 5: break held for 20 bit times
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(20 * OVS);
        check("t5_count", 32'(q_data.size()), 32'd1);
        expect_beat("t5", 9'h000, 3'b110);
        wait_ticks(2 * OVS);
        check("t5_held", 32'(q_data.size()), 32'd0);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(2 * OVS);
        send_frame(9'h081, 8, 0, 0, 0, 0);
        expect_beat("t5_after", 9'h081, 3'b000);

        // 6: overflow with sink stalled, drain, then a 9-bit character
        m_tready = 1'b0;
        for (int b = 1; b <= 5; b++) send_frame(9'(b), 8, 0, 0, 0, 0);
        check("t6_level_full", 32'(level), 32'd4);
        check("t6_overflow", 32'(ovf_cnt), 32'd1);
        check("t6_tvalid", 32'(m_tvalid), 32'd1);
        check("t6_head_stable", 32'(m_tdata), 32'h001);
        @(negedge clk);
        m_tready = 1'b1;
        wait_ticks(8);
        check("t6_drained", 32'(q_data.size()), 32'd4);
        expect_beat("t6_b1", 9'h001, 3'b000);
        expect_beat("t6_b2", 9'h002, 3'b000);
        expect_beat("t6_b3", 9'h003, 3'b000);
        expect_beat("t6_b4", 9'h004, 3'b000);
        check("t6_level_empty", 32'(level), 32'd0);
        set_cfg(4'd9, 2'd0, 1'b0);
        send_frame(9'h1FF, 9, 0, 0, 0, 0);
        expect_beat("t6_9bit", 9'h1FF, 3'b000);

        // 7: reset mid-frame flushes the FIFO and emits no pulses
        set_cfg(4'd8, 2'd0, 1'b0);
        m_tready = 1'b0;
        send_frame(9'h033, 8, 0, 0, 0, 0);
        check("t7_level_pre", 32'(level), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("t7_level_rst", 32'(level), 32'd0);
        check("t7_tvalid_rst", 32'(m_tvalid), 32'd0);
        check("t7_ovf_rst", 32'(overflow), 32'd0);
        check("t7_serr_rst", 32'(start_err), 32'd0);
        rst = 1'b0;
        m_tready = 1'b1;
        wait_ticks(12 * OVS);
        check("t7_no_beat", 32'(q_data.size()), 32'd0);
        check("t7_ovf_total", 32'(ovf_cnt), 32'd1);
        check("t7_serr_total", 32'(serr_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gj_axis_uart_rx_fifo.md
Name: gj_axis_uart_rx_fifo

Overview:
Parametrised next-generation UART receiver with AXI-Stream master output. It supports runtime-selectable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits) and a parametrised oversampling ratio. Received characters go into an internal FWFT FIFO that honours m_tready, with per-character error flags for break, framing and parity, and an overflow indication. It sits between the pad-side rx line and the AXIS fabric, clocked from clk and paced by an external oversampling tick.

Parameters:
OVS, 16, oversampling ticks per bit; must be even and >= 4.
DW, 9, output data width; must be >= 9 so the widest character fits.
DEPTH, 8, FIFO entries; must be a power of 2 and >= 2.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
clk_en  in  1  oversample tick, OVS ticks per bit time; one clk wide.
cfg_dbits  in  4  data bits, 5..9; values outside that range are treated as 8.
cfg_parity  in  2  0 none, 1 odd, 2 even, 3 none.
cfg_stop2  in  1  0: 1 stop bit; 1: 2 stop bits.
rx  in  1  asynchronous serial input, idle high.
m_tvalid  out  1  FIFO not empty.
m_tready  in  1  downstream accept.
m_tdata  out  DW  received character, LSB-aligned, zero-extended.
m_tuser  out  3  {break, frame_err, parity_err} for the m_tdata character.
overflow  out  1  one-clk pulse: a completed character was dropped because the FIFO was full.
start_err  out  1  one-clk pulse: a false start bit was rejected.
level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: state IDLE, FIFO empty, m_tvalid=0, m_tdata=0, m_tuser=0, overflow=0, start_err=0, level=0. Synchroniser flops and last-rx register reset to 1.
- rx passes through a 2-flop synchroniser on every clk (rxs). Start detection and sampling use rxs only on clk_en cycles.
- Config is latched into shadow registers on start detection. Config changes mid-frame do not affect the frame in progress.
- Bit timing:
  - Phase counter runs 0..OVS-1 per bit and advances on clk_en only.
  - Each bit value is the majority of 3 rxs samples taken at phases OVS/2-1, OVS/2 and OVS/2+1.
  - The bit decision is made at phase OVS/2+1, called the "decision tick".
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT.
  - IDLE -> START: on a clk_en where last-sampled rxs=1 and current rxs=0. Phase is set to 0.
  - START decision tick: if majority=1, pulse start_err and return to IDLE. Otherwise go to DATA.
  - DATA: shift bits in LSB first. After cfg_dbits bits go to PARITY if parity is enabled, otherwise to STOP1.
  - PARITY: parity_err = (received parity bit) != (expected parity bit). Expected even: XOR of data. Expected odd: inverted XOR of data.
  - STOP1 decision tick:
    - frame_err |= (majority==0).
    - break = all data bits 0, parity bit 0 (if present), and stop bit 0.
    - If cfg_stop2=1, go to STOP2. Otherwise push the character.
  - STOP2 decision tick: frame_err |= (majority==0), then push the character.
  - After a push: if break=1 go to BRKWAIT, otherwise go to IDLE. Returning at the decision tick leaves half a bit of margin to resync on the next start.
  - BRKWAIT: stay until rxs=1 on a clk_en, then go to IDLE. No start is detected while in BRKWAIT.
- Push and FIFO:
  - Push writes {break, frame_err, parity_err, data} in the decision-tick clk.
  - m_tvalid rises the following clk if the FIFO was empty.
  - Pop occurs when m_tvalid & m_tready.
  - Push while full with no simultaneous pop: the character is dropped, overflow pulses for 1 clk, and FIFO contents are unchanged.
  - Push while full with a simultaneous pop: the push is accepted and level is unchanged.
  - m_tdata/m_tuser are stable while m_tvalid=1 and m_tready=0.
- Pointers wrap modulo DEPTH. level equals writes minus reads.
- rst mid-frame: the frame is abandoned, the FIFO is flushed, and no pulses are emitted in the reset cycle.
- clk_en=0 freezes all bit timing. The FIFO side keeps operating every clk.

Test Plan:
1. OVS=16, 8N1, send 0xA5, m_tready=1 -> one beat with m_tdata=0x0A5, m_tuser=3'b000, level returns to 0.
2. 7E2, send 0x3C with correct parity, then 0x3C with the parity bit flipped -> beats 0x03C/000, then 0x03C/001.
3. 8N1, 0x55 with stop bit forced low -> m_tuser=3'b010. Next byte 0x12 with a valid frame -> 0x012/000.
4. rx low for 4 ticks only, then high -> start_err pulses once, no beat, FSM back in IDLE.
5. Hold rx low for 20 bit times, 8N1 -> single beat 0x000 with m_tuser=3'b110. No further beats until rx high. A following 0x81 is received cleanly.
6. DEPTH=4, m_tready=0, send 5 bytes 0x01..0x05 -> level=4, overflow pulses once on byte 5. Drain -> 0x01..0x04 in order. 9N1 0x1FF -> m_tdata=0x1FF.
